band_threshold_trigger: RTL and testbench

//  Consumer of the three user-set band thresholds (low/middle/high). Scales per-band audio

---
 rtl/audio_light_pkg.sv | 18 +
 rtl/band_trigger_fsm.sv | 98 +++++++++
 rtl/band_threshold_trigger.sv | 76 +++++++
 tb/tb_band_threshold_trigger.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/audio_light_pkg.sv
// Shared band indices, per-band trigger states and the magnitude-to-bar scaling helper.
package audio_light_pkg;

  localparam int BAND_HIGH = 0;
  localparam int BAND_MID  = 1;
  localparam int BAND_LOW  = 2;

  typedef enum logic [1:0] {TRIG_OFF, TRIG_HOLD, TRIG_TRACK} trig_state_t;

  function automatic logic [31:0] scale_level(input logic [31:0] mag,
                                              input int unsigned shift,
                                              input logic [31:0] max_level);
    logic [31:0] shifted;
    shifted = mag >> shift;
    return (shifted > max_level) ? max_level : shifted;
  endfunction

endpackage

// File: rtl/band_trigger_fsm.sv
// One band: OFF/HOLD/TRACK light FSM with minimum-on hold counter; light/pulse valid one clk after level_valid.
// No backpressure. THRESHOLD_HYSTERESIS_EN lowers the turn-off level by HYST pixels.
module band_trigger_fsm
  import audio_light_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 3062500,
  parameter int unsigned HYST        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        level_valid,
  input  logic [31:0] level,
  input  logic [31:0] threshold,
  output logic        light,
  output logic        pulse
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

`ifdef THRESHOLD_HYSTERESIS_EN
  localparam logic [31:0] HYST_EFF = 32'(HYST);
`else
  // Margin collapses to zero, so the off level equals the threshold itself.
  localparam logic [31:0] HYST_EFF = 32'(HYST * 0);
`endif

  trig_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_d;
  logic          enabled;
  logic          above;
  logic          below_off;
  logic [31:0]   off_th;

  assign enabled   = (threshold != 32'd0);
  assign above     = enabled && (level >= threshold);
  // Saturates at 1 so a zero level always turns the light off.
  assign off_th    = (threshold > HYST_EFF) ? (threshold - HYST_EFF) : 32'd1;
  assign below_off = (level < off_th);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      TRIG_OFF: begin
        if (level_valid && above) begin
          state_d = TRIG_HOLD;
          cnt_d   = RELOAD;
          pulse_d = 1'b1;
        end
      end
      TRIG_HOLD: begin
        if (level_valid && above) begin
          cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
          state_d = TRIG_TRACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TRIG_TRACK: begin
        if (level_valid && above) begin
          state_d = TRIG_HOLD;
          cnt_d   = RELOAD;
        end else if (level_valid && below_off) begin
          state_d = TRIG_OFF;
        end
      end
      default: begin
        state_d = TRIG_OFF;
        cnt_d   = '0;
      end
    endcase
    // Disabling the band overrides any remaining hold time.
    if (!enabled && (state_q != TRIG_OFF)) begin
      state_d = TRIG_OFF;
      cnt_d   = '0;
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRIG_OFF;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse   <= pulse_d;
    end
  end

  assign light = (state_q != TRIG_OFF);

endmodule

// File: rtl/band_threshold_trigger.sv
// Scales three band magnitudes to saturated bar levels (1 clk) and drives per-band lights/triggers (2 clk).
// No backpressure: every sample_valid is processed. THRESHOLD_HYSTERESIS_EN enables off-hysteresis.
module band_threshold_trigger
  import audio_light_pkg::*;
#(
  parameter int unsigned BAR_REGION_HEIGHT = 359,
  parameter int unsigned MAG_SHIFT         = 8,
  parameter int unsigned HOLD_CYCLES       = 3062500,
  parameter int unsigned HYST              = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [31:0] mag_low,
  input  logic [31:0] mag_mid,
  input  logic [31:0] mag_high,
  input  logic [31:0] low_threshold,
  input  logic [31:0] middle_threshold,
  input  logic [31:0] high_threshold,
  output logic [31:0] bar_level_low,
  output logic [31:0] bar_level_mid,
  output logic [31:0] bar_level_high,
  output logic        level_valid,
  output logic [2:0]  light_on,
  output logic [2:0]  trigger_pulse
);

  localparam logic [31:0] BAR_MAX = 32'(BAR_REGION_HEIGHT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_level_low  <= '0;
      bar_level_mid  <= '0;
      bar_level_high <= '0;
      level_valid    <= 1'b0;
    end else begin
      level_valid <= sample_valid;
      if (sample_valid) begin
        bar_level_low  <= scale_level(mag_low,  MAG_SHIFT, BAR_MAX);
        bar_level_mid  <= scale_level(mag_mid,  MAG_SHIFT, BAR_MAX);
        bar_level_high <= scale_level(mag_high, MAG_SHIFT, BAR_MAX);
      end
    end
  end

  band_trigger_fsm #(.HOLD_CYCLES(HOLD_CYCLES), .HYST(HYST)) u_band_low (
    .clk         (clk),
    .rst_n       (rst_n),
    .level_valid (level_valid),
    .level       (bar_level_low),
    .threshold   (low_threshold),
    .light       (light_on[BAND_LOW]),
    .pulse       (trigger_pulse[BAND_LOW])
  );

  band_trigger_fsm #(.HOLD_CYCLES(HOLD_CYCLES), .HYST(HYST)) u_band_mid (
    .clk         (clk),
    .rst_n       (rst_n),
    .level_valid (level_valid),
    .level       (bar_level_mid),
    .threshold   (middle_threshold),
    .light       (light_on[BAND_MID]),
    .pulse       (trigger_pulse[BAND_MID])
  );

  band_trigger_fsm #(.HOLD_CYCLES(HOLD_CYCLES), .HYST(HYST)) u_band_high (
    .clk         (clk),
    .rst_n       (rst_n),
    .level_valid (level_valid),
    .level       (bar_level_high),
    .threshold   (high_threshold),
    .light       (light_on[BAND_HIGH]),
    .pulse       (trigger_pulse[BAND_HIGH])
  );

endmodule

// File: tb/tb_band_threshold_trigger.sv
// Directed bench for band_threshold_trigger with HOLD_CYCLES=16, MAG_SHIFT=8, HYST=8.
module tb_band_threshold_trigger;

  logic        clk;
  logic        rst_n;
  logic        sample_valid;
  logic [31:0] mag_low, mag_mid, mag_high;
  logic [31:0] low_threshold, middle_threshold, high_threshold;
  logic [31:0] bar_level_low, bar_level_mid, bar_level_high;
  logic        level_valid;
  logic [2:0]  light_on;
  logic [2:0]  trigger_pulse;

  int n_checks = 0;
  int n_fails  = 0;
  int pulses;

  band_threshold_trigger #(
    .BAR_REGION_HEIGHT(359),
    .MAG_SHIFT(8),
    .HOLD_CYCLES(16),
    .HYST(8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_valid     (sample_valid),
    .mag_low          (mag_low),
    .mag_mid          (mag_mid),
    .mag_high         (mag_high),
    .low_threshold    (low_threshold),
    .middle_threshold (middle_threshold),
    .high_threshold   (high_threshold),
    .bar_level_low    (bar_level_low),
    .bar_level_mid    (bar_level_mid),
    .bar_level_high   (bar_level_high),
    .level_valid      (level_valid),
    .light_on         (light_on),
    .trigger_pulse    (trigger_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle sample; returns just after the capturing edge (bar levels visible).
  task automatic send(input logic [31:0] lo, input logic [31:0] mi, input logic [31:0] hi);
    sample_valid = 1'b1;
    mag_low  = lo;
    mag_mid  = mi;
    mag_high = hi;
    step();
    sample_valid = 1'b0;
    mag_low  = '0;
    mag_mid  = '0;
    mag_high = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    sample_valid = 1'b0;
    mag_low = '0; mag_mid = '0; mag_high = '0;
    low_threshold = '0; middle_threshold = '0; high_threshold = '0;
    repeat (2) step();
    check("rst_light", {29'd0, light_on}, 32'd0);
    check("rst_pulse", {29'd0, trigger_pulse}, 32'd0);
    check("rst_lvl_valid", {31'd0, level_valid}, 32'd0);
    check("rst_bar_low", bar_level_low, 32'd0);
    rst_n = 1'b1;
    step();

    // Scaling and saturation
    send(32'h0000_6400, 32'h0000_00FF, 32'h0001_6700);
    check("scale_low_100", bar_level_low, 32'd100);
    check("scale_mid_0", bar_level_mid, 32'd0);
    check("scale_high_359", bar_level_high, 32'd359);
    check("lvl_valid_hi", {31'd0, level_valid}, 32'd1);
    step();
    check("lvl_valid_lo", {31'd0, level_valid}, 32'd0);
    check("no_light_th0", {29'd0, light_on}, 32'd0);
    send(32'hFFFF_FFFF, 32'h0001_6800, 32'h0001_66FF);
    check("sat_low", bar_level_low, 32'd359);
    check("sat_mid_360", bar_level_mid, 32'd359);
    check("scale_high_358", bar_level_high, 32'd358);
    step();

    // Trigger and minimum hold on the low band
    low_threshold = 32'd100;
    send(100 << 8, 0, 0);
    step();
    check("trig_light", {29'd0, light_on}, 32'b100);
    check("trig_pulse", {29'd0, trigger_pulse}, 32'b100);
    step();
    check("trig_pulse_1cyc", {29'd0, trigger_pulse}, 32'd0);
    repeat (13) step();
    send(0, 0, 0);
    check("hold_e17", {31'd0, light_on[2]}, 32'd1);
    step();
    check("hold_e18_low_ignored", {31'd0, light_on[2]}, 32'd1);
    send(0, 0, 0);
    check("track_on", {31'd0, light_on[2]}, 32'd1);
    step();
    check("track_off", {29'd0, light_on}, 32'd0);
    check("track_off_pulse", {29'd0, trigger_pulse}, 32'd0);

    // Retrigger every 10 clocks: one pulse only
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      send(32'h0000_6400, 0, 0);
      for (int j = 0; j < 9; j++) begin
        step();
        if (trigger_pulse[2]) pulses++;
      end
      check($sformatf("retrig_on_%0d", i), {31'd0, light_on[2]}, 32'd1);
    end
    check("retrig_pulses", pulses, 32'd1);
    low_threshold = 32'd0;
    step();
    check("low_disable", {29'd0, light_on}, 32'd0);

    // Disable the high band while on
    high_threshold = 32'd200;
    send(0, 0, 300 << 8);
    step();
    check("high_on", {29'd0, light_on}, 32'b001);
    check("high_pulse", {29'd0, trigger_pulse}, 32'b001);
    repeat (3) step();
    high_threshold = 32'd0;
    step();
    check("high_disable", {29'd0, light_on}, 32'd0);
    send(0, 0, 300 << 8);
    step();
    check("high_disabled_pulse", {29'd0, trigger_pulse}, 32'd0);
    check("high_disabled_light", {29'd0, light_on}, 32'd0);

    // Asynchronous reset mid-HOLD
    high_threshold = 32'd200;
    send(0, 0, 300 << 8);
    step();
    check("pre_rst_on", {29'd0, light_on}, 32'b001);
    step();
    rst_n = 1'b0;
    #1;
    check("async_rst_light", {29'd0, light_on}, 32'd0);
    check("async_rst_pulse", {29'd0, trigger_pulse}, 32'd0);
    check("async_rst_bar_high", bar_level_high, 32'd0);
    check("async_rst_bar_low", bar_level_low, 32'd0);
    #3;
    rst_n = 1'b1;
    high_threshold = 32'd0;
    step();
    check("post_rst_off", {29'd0, light_on}, 32'd0);

    // Turn-off level in TRACK
    low_threshold = 32'd100;
    send(100 << 8, 0, 0);
    repeat (20) step();
    check("hyst_track_on", {31'd0, light_on[2]}, 32'd1);
`ifdef THRESHOLD_HYSTERESIS_EN
    send(95 << 8, 0, 0);
    step();
    check("hyst_95_on", {31'd0, light_on[2]}, 32'd1);
    send(92 << 8, 0, 0);
    step();
    check("hyst_92_on", {31'd0, light_on[2]}, 32'd1);
    send(91 << 8, 0, 0);
    step();
    check("hyst_91_off", {31'd0, light_on[2]}, 32'd0);
`else
    send(100 << 8, 0, 0);
    repeat (20) step();
    send(99 << 8, 0, 0);
    step();
    check("nohyst_99_off", {31'd0, light_on[2]}, 32'd0);
`endif
    check("hyst_no_pulse", {29'd0, trigger_pulse}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
